// File: rtl/sysbus_arbiter_rr.sv
// N-way Sysbus arbiter: grants one requester at a time, forwards its request and data burst
// or routes the read response beats back to it; round-robin or fixed-priority grant.
module sysbus_arbiter_rr #(
   parameter int unsigned NUM_PORTS      = 2,
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned LINE_BEATS     = 8,
   parameter int unsigned WRITE_TAG_BIT  = 12,
   parameter int unsigned PRIORITY_MODE  = 0,
   localparam int unsigned OwnerW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_PORTS-1:0]                port_reqcyc,
   input  logic [NUM_PORTS*BUS_DATA_WIDTH-1:0] port_req,
   input  logic [NUM_PORTS*BUS_TAG_WIDTH-1:0]  port_reqtag,
   input  logic [NUM_PORTS-1:0]                port_respack,
   output logic [NUM_PORTS-1:0]                port_reqack,
   output logic [NUM_PORTS-1:0]                port_respcyc,
   output logic [BUS_DATA_WIDTH-1:0]           port_resp,
   output logic [BUS_TAG_WIDTH-1:0]            port_resptag,
   output logic                                bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0]           bus_req,
   output logic [BUS_TAG_WIDTH-1:0]            bus_reqtag,
   input  logic                                bus_reqack,
   input  logic                                bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]           bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]            bus_resptag,
   output logic                                bus_respack,
   output logic [OwnerW-1:0]                   owner,
   output logic                                err_orphan_resp
);

   localparam int unsigned BeatW = $clog2(LINE_BEATS) + 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_BEATS - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StReq   = 2'd1;
   localparam logic [1:0] StWdata = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [OwnerW-1:0]         owner_q, owner_d;
   logic [OwnerW-1:0]         last_q, last_d;
   logic [BeatW-1:0]          beat_q, beat_d;
   logic                      err_q, err_d;

   logic                      arb_valid;
   logic [OwnerW-1:0]         arb_idx;
   logic [OwnerW-1:0]         cand;
   int unsigned               cand_int;

   logic                      own_reqcyc;
   logic                      own_respack;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_tag;
   logic [NUM_PORTS-1:0]      owner_oh;
   logic                      resp_fire;

   always_comb begin
      own_reqcyc  = 1'b0;
      own_respack = 1'b0;
      own_req     = '0;
      own_tag     = '0;
      owner_oh    = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (owner_q == OwnerW'(i)) begin
            own_reqcyc  = port_reqcyc[i];
            own_respack = port_respack[i];
            own_req     = port_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            own_tag     = port_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
            owner_oh[i] = 1'b1;
         end
      end
   end

   // Search order starts just past the last completed owner (round-robin) or at port 0.
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      cand_int  = 0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (PRIORITY_MODE != 0) begin
            cand_int = k;
         end else begin
            cand_int = (32'(last_q) + 32'd1 + k) % NUM_PORTS;
         end
         cand = OwnerW'(cand_int);
         if (!arb_valid && port_reqcyc[cand]) begin
            arb_valid = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   assign resp_fire = (state_q == StResp) && bus_respcyc && own_respack;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      beat_d  = beat_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (arb_valid) begin
               owner_d = arb_idx;
               state_d = StReq;
            end
         end
         StReq: begin
            if (!own_reqcyc) begin
               state_d = StIdle;
            end else if (bus_reqack) begin
               state_d = own_tag[WRITE_TAG_BIT] ? StWdata : StResp;
               beat_d  = '0;
            end
         end
         StWdata: begin
            if (own_reqcyc) begin
               if (beat_q == LastBeat) begin
                  state_d = StIdle;
                  last_d  = owner_q;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StResp: begin
            if (resp_fire) begin
               if (beat_q == LastBeat) begin
                  state_d = StIdle;
                  last_d  = owner_q;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (bus_respcyc && (state_q != StResp)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= OwnerW'(NUM_PORTS - 1);
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      bus_reqcyc   = 1'b0;
      bus_req      = '0;
      bus_reqtag   = '0;
      port_reqack  = '0;
      port_respcyc = '0;
      port_resp    = '0;
      port_resptag = '0;
      bus_respack  = 1'b0;
      if ((state_q == StReq) || (state_q == StWdata)) begin
         bus_reqcyc = own_reqcyc;
         bus_req    = own_req;
         bus_reqtag = own_tag;
      end
      if (state_q == StReq) begin
         port_reqack = bus_reqack ? owner_oh : '0;
      end
      if (state_q == StResp) begin
         port_respcyc = bus_respcyc ? owner_oh : '0;
         bus_respack  = own_respack & bus_respcyc;
         port_resp    = bus_resp;
         port_resptag = bus_resptag;
      end
   end

   assign owner           = owner_q;
   assign err_orphan_resp = err_q;

endmodule

// File: tb/tb_sysbus_arbiter_rr.sv
// Bench for sysbus_arbiter_rr: a 4-port round-robin instance driven by directed and random
// transactions against a grant-order model, plus a 4-port fixed-priority instance.
module tb_sysbus_arbiter_rr;

   logic         clk;
   logic         reset;
   logic [3:0]   port_reqcyc;
   logic [255:0] port_req;
   logic [51:0]  port_reqtag;
   logic [3:0]   port_respack;
   logic [3:0]   port_reqack;
   logic [3:0]   port_respcyc;
   logic [63:0]  port_resp;
   logic [12:0]  port_resptag;
   logic         bus_reqcyc;
   logic [63:0]  bus_req;
   logic [12:0]  bus_reqtag;
   logic         bus_reqack;
   logic         bus_respcyc;
   logic [63:0]  bus_resp;
   logic [12:0]  bus_resptag;
   logic         bus_respack;
   logic [1:0]   owner;
   logic         err_orphan_resp;

   logic [3:0]   b_reqcyc;
   logic [3:0]   b_respack;
   logic         b_reqack;
   logic         b_respcyc;
   logic [3:0]   b_port_reqack;
   logic [3:0]   b_port_respcyc;
   logic [63:0]  b_port_resp;
   logic [12:0]  b_port_resptag;
   logic         b_bus_reqcyc;
   logic [63:0]  b_bus_req;
   logic [12:0]  b_bus_reqtag;
   logic         b_bus_respack;
   logic [1:0]   b_owner;
   logic         b_err;

   int checks;
   int errors;
   int last;

   sysbus_arbiter_rr #(
      .NUM_PORTS(4), .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LINE_BEATS(8),
      .WRITE_TAG_BIT(12), .PRIORITY_MODE(0)
   ) dut (
      .clk(clk), .reset(reset), .port_reqcyc(port_reqcyc), .port_req(port_req),
      .port_reqtag(port_reqtag), .port_respack(port_respack), .port_reqack(port_reqack),
      .port_respcyc(port_respcyc), .port_resp(port_resp), .port_resptag(port_resptag),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
      .bus_resptag(bus_resptag), .bus_respack(bus_respack), .owner(owner),
      .err_orphan_resp(err_orphan_resp)
   );

   sysbus_arbiter_rr #(
      .NUM_PORTS(4), .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LINE_BEATS(8),
      .WRITE_TAG_BIT(12), .PRIORITY_MODE(1)
   ) dut_pri (
      .clk(clk), .reset(reset), .port_reqcyc(b_reqcyc), .port_req(port_req),
      .port_reqtag(port_reqtag), .port_respack(b_respack), .port_reqack(b_port_reqack),
      .port_respcyc(b_port_respcyc), .port_resp(b_port_resp), .port_resptag(b_port_resptag),
      .bus_reqcyc(b_bus_reqcyc), .bus_req(b_bus_req), .bus_reqtag(b_bus_reqtag),
      .bus_reqack(b_reqack), .bus_respcyc(b_respcyc), .bus_resp(bus_resp),
      .bus_resptag(bus_resptag), .bus_respack(b_bus_respack), .owner(b_owner),
      .err_orphan_resp(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Round-robin rule: first requester after the last completed owner, wrapping.
   function automatic int rr_pick(input logic [3:0] mask, input int lst);
      for (int d = 1; d <= 4; d++) begin
         if (mask[2'((lst + d) % 4)]) return (lst + d) % 4;
      end
      return -1;
   endfunction

   task automatic new_req(input logic [1:0] p, input bit wr);
      port_reqcyc[p]          = 1'b1;
      port_req[p*64 +: 64]    = {30'd0, p, $urandom};
      port_reqtag[p*13 +: 13] = {wr, 12'($urandom)};
   endtask

   task automatic check_quiet(input string pfx);
      check({pfx, "_reqack"}, port_reqack, 0);
      check({pfx, "_respcyc"}, port_respcyc, 0);
      check({pfx, "_resp"}, port_resp, 0);
      check({pfx, "_resptag"}, port_resptag, 0);
      check({pfx, "_bus_reqcyc"}, bus_reqcyc, 0);
      check({pfx, "_bus_req"}, bus_req, 0);
      check({pfx, "_bus_reqtag"}, bus_reqtag, 0);
      check({pfx, "_bus_respack"}, bus_respack, 0);
      check({pfx, "_owner"}, owner, 0);
      check({pfx, "_err"}, err_orphan_resp, 0);
   endtask

   // One transaction, entered with the arbiter idle; returns at posedge+1 with it idle again,
   // except when abort_beat response beats have been accepted.
   task automatic run_txn(input bit rnd, input bit force_wd, input int abort_beat);
      int          e, lat, c, ns;
      logic [1:0]  ei;
      logic [12:0] tg;
      logic [63:0] d;
      bit          acc;
      e = rr_pick(port_reqcyc, last);
      check("have_request", 64'(e >= 0), 1);
      if (e < 0) return;
      ei = 2'(e);
      settle();
      check("idle_reqcyc", bus_reqcyc, 0);
      tick();
      settle();
      tg = port_reqtag[e*13 +: 13];
      check("grant_owner", owner, 64'(e));
      check("grant_reqcyc", bus_reqcyc, 1);
      check("grant_addr", bus_req, port_req[e*64 +: 64]);
      check("grant_tag", bus_reqtag, tg);
      check("grant_reqack", port_reqack, 0);
      if (force_wd || (rnd && $urandom_range(0, 7) == 0)) begin
         tick();
         port_reqcyc[ei] = 1'b0;
         settle();
         check("withdraw_reqcyc", bus_reqcyc, 0);
         tick();
         return;
      end
      lat = rnd ? $urandom_range(0, 3) : 2;
      repeat (lat) begin
         tick();
         settle();
         check("wait_reqack", port_reqack, 0);
         check("wait_reqcyc", bus_reqcyc, 1);
      end
      tick();
      bus_reqack = 1'b1;
      settle();
      check("reqack", port_reqack, 64'(4'b1 << e));
      tick();
      bus_reqack = 1'b0;
      if (tg[12]) begin
         for (int j = 0; j < 8; j++) begin
            ns = rnd ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0) : ((j == 3) ? 2 : 0);
            repeat (ns) begin
               port_reqcyc[ei] = 1'b0;
               settle();
               check("stall_reqcyc", bus_reqcyc, 0);
               tick();
            end
            d = rnd ? {$urandom, $urandom} : 64'(8'h11 + j);
            port_reqcyc[ei]      = 1'b1;
            port_req[e*64 +: 64] = d;
            settle();
            check("wdata_reqcyc", bus_reqcyc, 1);
            check("wdata_req", bus_req, d);
            check("wdata_respcyc", port_respcyc, 0);
            tick();
         end
         port_reqcyc[ei] = 1'b0;
      end else begin
         port_reqcyc[ei] = 1'b0;
         c = 0;
         for (int t = 0; t < 200 && c < 8; t++) begin
            bus_respcyc  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus_resp     = rnd ? {$urandom, $urandom} : 64'(8'hA0 + c);
            bus_resptag  = 13'($urandom);
            port_respack = rnd ? 4'($urandom) : 4'hF;
            settle();
            acc = bus_respcyc & port_respack[ei];
            check("resp_cyc", port_respcyc, bus_respcyc ? 64'(4'b1 << e) : 64'd0);
            check("resp_ack", bus_respack, 64'(acc));
            check("resp_reqcyc", bus_reqcyc, 0);
            if (bus_respcyc) begin
               check("resp_data", port_resp, bus_resp);
               check("resp_tag", port_resptag, bus_resptag);
            end
            tick();
            if (acc) c++;
            if (c == abort_beat) return;
         end
         bus_respcyc  = 1'b0;
         port_respack = '0;
         check("resp_beats", 64'(c), 8);
      end
      last = e;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      last         = 3;
      reset        = 1'b0;
      port_reqcyc  = '0;
      port_req     = '0;
      port_reqtag  = '0;
      port_respack = '0;
      bus_reqack   = 1'b0;
      bus_respcyc  = 1'b0;
      bus_resp     = '0;
      bus_resptag  = '0;
      b_reqcyc     = '0;
      b_respack    = '0;
      b_reqack     = 1'b0;
      b_respcyc    = 1'b0;

      settle();
      check_quiet("reset");
      tick();
      reset = 1'b1;

      // All four ports request reads continuously; owner re-requests when its read ends.
      for (int p = 0; p < 4; p++) new_req(2'(p), 1'b0);
      for (int n = 0; n < 5; n++) begin
         run_txn(1'b0, 1'b0, -1);
         new_req(2'(last), 1'b0);
      end
      port_reqcyc = '0;

      // Write burst from port 1 with a two-cycle stall after the third beat.
      new_req(2'd1, 1'b1);
      run_txn(1'b0, 1'b0, -1);

      // Port 2 withdraws before ack; port 3 takes the next grant.
      new_req(2'd2, 1'b0);
      new_req(2'd3, 1'b0);
      run_txn(1'b0, 1'b1, -1);
      run_txn(1'b0, 1'b0, -1);

      for (int n = 0; n < 40; n++) begin
         if (port_reqcyc == 4'd0) new_req(2'($urandom_range(0, 3)), 1'($urandom));
         run_txn(1'b1, 1'b0, -1);
         for (int p = 0; p < 4; p++) begin
            if (!port_reqcyc[p] && $urandom_range(0, 2) == 0) new_req(2'(p), 1'($urandom));
         end
      end
      port_reqcyc = '0;
      settle();
      check("no_orphan", err_orphan_resp, 0);
      tick();

      // Fixed priority: ports 0 and 3 request continuously, port 0 always wins.
      port_req[0 +: 64]     = 64'h2000;
      port_req[192 +: 64]   = 64'h5000;
      port_reqtag[0 +: 13]  = 13'h0ab;
      port_reqtag[39 +: 13] = 13'h0cd;
      b_reqcyc  = 4'b1001;
      b_respack = 4'b1001;
      for (int n = 0; n < 4; n++) begin
         tick();
         settle();
         check("pri_reqcyc", b_bus_reqcyc, 1);
         check("pri_owner", b_owner, 0);
         check("pri_tag", b_bus_reqtag, 13'h0ab);
         tick();
         b_reqack = 1'b1;
         settle();
         check("pri_reqack", b_port_reqack, 4'b0001);
         tick();
         b_reqack  = 1'b0;
         b_respcyc = 1'b1;
         repeat (8) begin
            settle();
            check("pri_respcyc", b_port_respcyc, 4'b0001);
            tick();
         end
         b_respcyc = 1'b0;
      end
      b_reqcyc = '0;

      // Reset in the middle of a read, then a response beat with nothing outstanding.
      new_req(2'd0, 1'b0);
      run_txn(1'b0, 1'b0, 4);
      #1;
      check("pre_reset_respcyc", port_respcyc, 4'b0001);
      reset = 1'b0;
      #1;
      check_quiet("async_reset");
      tick();
      tick();
      reset = 1'b1;
      last  = 3;
      settle();
      check("orphan_respack", bus_respack, 0);
      check("orphan_respcyc", port_respcyc, 0);
      check("orphan_err_pre", err_orphan_resp, 0);
      tick();
      bus_respcyc = 1'b0;
      settle();
      check("orphan_err_set", err_orphan_resp, 1);
      tick();
      tick();
      settle();
      check("orphan_err_sticky", err_orphan_resp, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysbus_arbiter_rr.md
Name: sysbus_arbiter_rr

Overview:
- N-way parametrised successor to the two-port instruction/data bus arbiter.
- Multiplexes NUM_PORTS Sysbus requesters (fetcher, data memory, page walker, etc.) onto the single top-level Sysbus.
- Holds one transaction at a time; ownership lasts until the read response or write data burst completes.
- Grant policy is round-robin or fixed priority, selected by parameter; response beats are routed to the owning port.

Parameters:
- NUM_PORTS, 2: number of requester ports (2..8).
- BUS_DATA_WIDTH, 64: Sysbus data width.
- BUS_TAG_WIDTH, 13: Sysbus tag width.
- LINE_BEATS, 8: data beats per write burst and per read response.
- WRITE_TAG_BIT, 12: reqtag bit that marks a write (1 = write, 0 = read).
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- port_reqcyc  in  NUM_PORTS  per-port request valid.
- port_req  in  NUM_PORTS*BUS_DATA_WIDTH  per-port address or write data; port i occupies bits [i*W +: W].
- port_reqtag  in  NUM_PORTS*BUS_TAG_WIDTH  per-port request tag.
- port_respack  in  NUM_PORTS  per-port response accept.
- port_reqack  out  NUM_PORTS  per-port request accepted.
- port_respcyc  out  NUM_PORTS  per-port response valid.
- port_resp  out  BUS_DATA_WIDTH  response data, broadcast; qualify with port_respcyc.
- port_resptag  out  BUS_TAG_WIDTH  response tag, broadcast.
- bus_reqcyc  out  1  Sysbus request valid.
- bus_req  out  BUS_DATA_WIDTH  Sysbus request address or data.
- bus_reqtag  out  BUS_TAG_WIDTH  Sysbus request tag.
- bus_reqack  in  1  Sysbus request accepted.
- bus_respcyc  in  1  Sysbus response valid.
- bus_resp  in  BUS_DATA_WIDTH  Sysbus response data.
- bus_resptag  in  BUS_TAG_WIDTH  Sysbus response tag.
- bus_respack  out  1  Sysbus response accept.
- owner  out  $clog2(NUM_PORTS) (min 1)  current grant index; debug only.
- err_orphan_resp  out  1  sticky flag: bus_respcyc seen with no read outstanding.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=0, last_grant=NUM_PORTS-1, beat counter=0, err_orphan_resp=0.
  - All outputs 0.
  - A reset mid-transaction abandons it immediately; no cleanup beats are issued.
- IDLE:
  - Arbitration is combinational over port_reqcyc.
  - Round-robin: the first requesting index searched from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - Fixed priority: the lowest requesting index.
  - If any port requests: owner is registered, state->REQ. Arbitration latency is 1 cycle.
  - bus_reqcyc=0 in IDLE.
- REQ:
  - bus_reqcyc/bus_req/bus_reqtag = owner's port signals (combinational mux).
  - port_reqack[owner]=bus_reqack; all other bits 0.
  - On bus_reqack with tag[WRITE_TAG_BIT]=1: state->WDATA, beat counter=0.
  - On bus_reqack with tag[WRITE_TAG_BIT]=0: state->RESP, beat counter=0.
  - If the owner drops port_reqcyc before ack (withdrawal): state->IDLE, last_grant unchanged.
- WDATA:
  - bus_reqcyc/bus_req/bus_reqtag are forwarded from the owner.
  - One beat is counted per cycle in which port_reqcyc[owner]=1. A stalled beat (reqcyc=0) is not counted and drives bus_reqcyc=0.
  - After LINE_BEATS counted beats: state->IDLE, last_grant=owner. Writes produce no response.
- RESP:
  - port_respcyc[owner]=bus_respcyc.
  - bus_respack = port_respack[owner] & bus_respcyc.
  - port_resp/port_resptag are driven from bus_resp/bus_resptag.
  - One beat is counted per cycle with bus_respcyc & bus_respack.
  - When counter=LINE_BEATS-1 and a beat is accepted: state->IDLE, last_grant=owner.
  - bus_reqcyc=0 throughout RESP.
- Orphan response: bus_respcyc=1 in IDLE, REQ or WDATA gives bus_respack=0 and sets err_orphan_resp (cleared only by reset). All port_respcyc stay 0.
- Beat counter width: $clog2(LINE_BEATS)+1. The counter never wraps; it is compared for equality.
- Non-owning ports never see reqack or respcyc.
- Requests arriving during a transaction wait; there is no request buffering.
- A grant back-to-back with the end of a transaction is permitted: an IDLE decision is taken on the cycle after return.

Test Plan:
- Port 0 read: reqcyc addr 0x1000, tag bit12=0; reqack after 2 cycles; 8 resp beats 0xA0..0xA7 -> port_respcyc[0] high for 8 beats; port_resp matches; bus_respack mirrors port_respack[0]; returns to IDLE.
- NUM_PORTS=4, round-robin, all four requesting reads continuously -> grant order 0,1,2,3,0; each owner receives exactly 8 beats.
- Port 1 write: tag bit12=1, 8 data beats 0x11..0x18 with a 2-cycle stall after beat 3 -> bus_req carries all 8 values in order; bus_reqcyc=0 during stall; IDLE after beat 8; no respack.
- Withdrawal: port 2 drops reqcyc in REQ before ack -> IDLE next cycle; port 3 (also requesting) granted; last_grant unchanged.
- PRIORITY_MODE=1, ports 0 and 3 requesting continuously -> port 0 always granted; port 3 is never granted.
- Reset asserted at resp beat 4 -> all outputs 0 asynchronously; after release, bus_respcyc beat -> err_orphan_resp=1; bus_respack=0.
